// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA/glyph constants, colour values and scan FSM state type
// Contents: active-area geometry, glyph cell size, 12-bit RGB constants,
// glyph_row_t (one 16-pixel ROM row, bit 0 = leftmost), scan_state_t.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int GLYPH_W  = 16;
  localparam int GLYPH_H  = 16;

  localparam logic [11:0] RGB_BLACK = 12'h000;
  localparam logic [11:0] RGB_WHITE = 12'hFFF;

  typedef logic [GLYPH_W-1:0] glyph_row_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } scan_state_t;

endpackage

// File: rtl/glyph_scanout_if.sv
// rtl/glyph_scanout_if.sv - timing/ROM/pixel signal bundle for one glyph scanout instance
// Signals: pixel_tick, hc, vc, vidon and rom_data flow into the scanout;
// rom_addr, pix_on, rgb and busy flow out. slave = the scanout block,
// master = the VGA timing / ROM / mixer side.
interface glyph_scanout_if;
  import vga_pkg::*;

  logic        pixel_tick;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic        vidon;
  logic [3:0]  rom_addr;
  glyph_row_t  rom_data;
  logic        pix_on;
  logic [11:0] rgb;
  logic        busy;

  modport master (
    output pixel_tick, hc, vc, vidon, rom_data,
    input  rom_addr, pix_on, rgb, busy
  );

  modport slave (
    input  pixel_tick, hc, vc, vidon, rom_data,
    output rom_addr, pix_on, rgb, busy
  );

endinterface

// File: rtl/glyph_shifter.sv
// rtl/glyph_shifter.sv - glyph row shift register with column and magnification counters
// Ports: clk, rst_n (async, active low); load_i latches data_i and clears the
// counters; advance_i steps one output tick; abort_i clears everything.
// bit_o is the pixel currently at the head of the row, last_o flags the final
// tick of the row (col 15, last sub-step).
module glyph_shifter
  import vga_pkg::*;
#(
  parameter int SCALE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       advance_i,
  input  logic       abort_i,
  input  glyph_row_t data_i,
  output logic       bit_o,
  output logic       last_o
);

  localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(SCALE - 1);

  glyph_row_t       shreg_q, shreg_d;
  logic [3:0]       col_q, col_d;
  logic [SUB_W-1:0] sub_q, sub_d;

  always_comb begin
    shreg_d = shreg_q;
    col_d   = col_q;
    sub_d   = sub_q;
    if (abort_i) begin
      shreg_d = '0;
      col_d   = '0;
      sub_d   = '0;
    end else if (load_i) begin
      shreg_d = data_i;
      col_d   = '0;
      sub_d   = '0;
    end else if (advance_i) begin
      // Each glyph pixel is repeated SCALE times before the next one moves to bit 0.
      if (sub_q == SUB_MAX) begin
        sub_d   = '0;
        shreg_d = shreg_q >> 1;
        col_d   = col_q + 4'd1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      col_q   <= '0;
      sub_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      col_q   <= col_d;
      sub_q   <= sub_d;
    end
  end

  assign bit_o  = shreg_q[0];
  assign last_o = (col_q == 4'd15) && (sub_q == SUB_MAX);

endmodule

// File: rtl/glyph_scanout.sv
// rtl/glyph_scanout.sv - reads one glyph ROM row per line and serializes it into RGB pixels
// Ports: clk, rst_n (async, active low); bus (slave) carries pixel_tick, hc, vc,
// vidon, rom_data in and rom_addr (combinational), pix_on, rgb, busy (registered) out.
// Parameters: X0/Y0 glyph box origin (X0 >= 1), SCALE magnification (1/2/4),
// FG_COLOR/BG_COLOR output colours.
module glyph_scanout
  import vga_pkg::*;
#(
  parameter int          X0       = 100,
  parameter int          Y0       = 50,
  parameter int          SCALE    = 1,
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input logic             clk,
  input logic             rst_n,
  glyph_scanout_if.slave  bus
);

  localparam logic [10:0] ROW_LO    = 11'(Y0);
  localparam logic [10:0] ROW_HI    = 11'(Y0 + GLYPH_H * SCALE);
  localparam int          ROW_SHIFT = $clog2(SCALE);
  // Loading one pixel early lets the first glyph pixel appear on the hc==X0 tick.
  localparam logic [9:0]  HC_LOAD   = 10'(X0 - 1);

  scan_state_t state_q, state_d;
  logic        pix_on_q, pix_on_d;
  logic [11:0] rgb_q, rgb_d;
  logic        busy_q, busy_d;

  logic       in_rows;
  logic [9:0] rel_row;
  logic       sh_load, sh_advance, sh_abort;
  logic       sh_bit, sh_last;

  assign in_rows = bus.vidon && ({1'b0, bus.vc} >= ROW_LO) && ({1'b0, bus.vc} < ROW_HI);
  assign rel_row = bus.vc - 10'(Y0);
  assign bus.rom_addr = in_rows ? 4'(rel_row >> ROW_SHIFT) : 4'd0;

  glyph_shifter #(
    .SCALE (SCALE)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (sh_load),
    .advance_i (sh_advance),
    .abort_i   (sh_abort),
    .data_i    (bus.rom_data),
    .bit_o     (sh_bit),
    .last_o    (sh_last)
  );

  always_comb begin
    state_d    = state_q;
    pix_on_d   = pix_on_q;
    rgb_d      = rgb_q;
    busy_d     = busy_q;
    sh_load    = 1'b0;
    sh_advance = 1'b0;
    sh_abort   = 1'b0;
    if (bus.pixel_tick) begin
      unique case (state_q)
        ST_IDLE: begin
          pix_on_d = 1'b0;
          rgb_d    = bus.vidon ? BG_COLOR : RGB_BLACK;
          busy_d   = 1'b0;
          if (in_rows && (bus.hc == HC_LOAD)) begin
            sh_load = 1'b1;
            busy_d  = 1'b1;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (!bus.vidon) begin
            // Blanking mid-row discards the rest of the row; it is not resumed.
            sh_abort = 1'b1;
            pix_on_d = 1'b0;
            rgb_d    = RGB_BLACK;
            busy_d   = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            sh_advance = 1'b1;
            pix_on_d   = sh_bit;
            rgb_d      = sh_bit ? FG_COLOR : BG_COLOR;
            if (sh_last) begin
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pix_on_q <= 1'b0;
      rgb_q    <= RGB_BLACK;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pix_on_q <= pix_on_d;
      rgb_q    <= rgb_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.pix_on = pix_on_q;
  assign bus.rgb    = rgb_q;
  assign bus.busy   = busy_q;

endmodule
